ifetch: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction cache and memory controller. It holds the program counter and issues one word fetch at a time to the icache. It accepts either a same-cycle cache hit or a later memory-controller return. Fetched instructions go into a small FWFT queue that the decoder drains, and a redirect from the branch/commit logic flushes the queue and restarts fetch.

---
 rtl/ifetch.sv | 179 +++++++++++++++++
 tb/tb_ifetch.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch
//  Purpose  : Instruction fetch stage. Holds the program counter and issues
//             one word fetch at a time to the icache. A fetch completes either
//             by a same-cycle icache hit or by a later memory-controller
//             return. Fetched words land in a small first-word-fall-through
//             queue that the decoder drains. A redirect flushes the queue and
//             restarts fetch at the new target.
//  Ports    : clk, rst        - clock, asynchronous active-high reset
//             rdy             - global enable, all state holds when low
//             fetchEn/Addr    - fetch request and address to the icache
//             hit/foundInst   - icache hit and data, same cycle as fetchEn
//             memInstEn/Inst  - memory-controller return pulse and word
//             jumpEn/Addr     - redirect request and target
//             instValid/Out/Pc- queue head towards the decoder
//             instRe          - decoder pops the queue head
//  Revision : 1.0 - initial release
// ============================================================================
module ifetch #(
  parameter int          QDEPTH = 4,
  parameter logic [31:0] RST_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        fetchEn,
  output logic [31:0] fetchAddr,
  input  logic        hit,
  input  logic [31:0] foundInst,
  input  logic        memInstEn,
  input  logic [31:0] memInst,
  input  logic        jumpEn,
  input  logic [31:0] jumpAddr,
  output logic        instValid,
  output logic [31:0] instOut,
  output logic [31:0] instPc,
  input  logic        instRe
);

  localparam int             c_AW   = $clog2(QDEPTH);
  localparam logic [c_AW:0]  c_FULL = (c_AW + 1)'(QDEPTH);

  // ISSUE: free to request. WAIT: a miss is outstanding at the memory
  // controller. DROP: a miss is outstanding but a redirect made it stale.
  localparam logic [1:0] c_ISSUE = 2'd0;
  localparam logic [1:0] c_WAIT  = 2'd1;
  localparam logic [1:0] c_DROP  = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [31:0]     r_pc;
  logic [31:0]     r_pending_pc;
  logic [31:0]     r_inst_mem [QDEPTH];
  logic [31:0]     r_pc_mem   [QDEPTH];
  logic [c_AW-1:0] r_head;
  logic [c_AW-1:0] r_tail;
  logic [c_AW:0]   r_count;

  logic            w_full;
  logic            w_fetch;
  logic            w_hit_push;
  logic            w_mem_push;
  logic            w_push;
  logic            w_pop;
  logic [31:0]     w_push_inst;
  logic [31:0]     w_push_pc;

  assign w_full = (r_count == c_FULL);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ISSUE;
    end else if (rdy) begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. A redirect never cancels the memory controller's
  // outstanding return, so a redirect during WAIT must still swallow that
  // word (DROP) unless it arrives in the very same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ISSUE: begin
        if (w_fetch && !hit) begin
          w_state_nxt = c_WAIT;
        end
      end
      c_WAIT: begin
        if (jumpEn) begin
          w_state_nxt = memInstEn ? c_ISSUE : c_DROP;
        end else if (memInstEn) begin
          w_state_nxt = c_ISSUE;
        end
      end
      c_DROP: begin
        if (memInstEn) begin
          w_state_nxt = c_ISSUE;
        end
      end
      default: w_state_nxt = c_ISSUE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. Fetch only when there is guaranteed room, so a miss return
  // can always be pushed without back-pressure.
  // --------------------------------------------------------------------------
  always_comb begin
    w_fetch = rdy && (r_state == c_ISSUE) && !w_full && !jumpEn;
  end

  assign fetchEn   = w_fetch;
  assign fetchAddr = r_pc;

  // --------------------------------------------------------------------------
  // Queue control
  // --------------------------------------------------------------------------
  assign w_hit_push  = w_fetch && hit;
  assign w_mem_push  = rdy && !jumpEn && (r_state == c_WAIT) && memInstEn;
  assign w_push      = w_hit_push || w_mem_push;
  assign w_pop       = rdy && !jumpEn && instRe && (r_count != '0);
  assign w_push_inst = (r_state == c_WAIT) ? memInst      : foundInst;
  assign w_push_pc   = (r_state == c_WAIT) ? r_pending_pc : r_pc;

  // --------------------------------------------------------------------------
  // PC, pending miss address and queue storage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RST_PC;
      r_pending_pc <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_inst_mem[i] <= '0;
        r_pc_mem[i]   <= '0;
      end
    end else if (rdy) begin
      if (jumpEn) begin
        // Flush: emptying the queue by collapsing head onto tail.
        r_pc    <= jumpAddr;
        r_head  <= r_tail;
        r_count <= '0;
      end else begin
        if (w_fetch && !hit) begin
          r_pending_pc <= r_pc;
        end
        if (w_push) begin
          r_inst_mem[r_tail] <= w_push_inst;
          r_pc_mem[r_tail]   <= w_push_pc;
          r_tail             <= r_tail + 1'b1;
          r_pc               <= r_pc + 32'd4;
        end
        if (w_pop) begin
          r_head <= r_head + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign instValid = (r_count != '0);
  assign instOut   = r_inst_mem[r_head];
  assign instPc    = r_pc_mem[r_head];

endmodule
`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifetch
//  Purpose  : Self-checking bench for ifetch. A stimulus process drives one
//             cycle at a time and advances a behavioural model (flags for an
//             outstanding/stale miss, a PC, and a queue of expected entries).
//             A separate monitor compares the DUT outputs each cycle against
//             the model and consumes expected entries as the decoder pops.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch;

  localparam int          QDEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b0;
  logic        fetchEn;
  logic [31:0] fetchAddr;
  logic        hit = 1'b0;
  logic [31:0] foundInst = '0;
  logic        memInstEn = 1'b0;
  logic [31:0] memInst = '0;
  logic        jumpEn = 1'b0;
  logic [31:0] jumpAddr = '0;
  logic        instValid;
  logic [31:0] instOut;
  logic [31:0] instPc;
  logic        instRe = 1'b0;

  ifetch #(.QDEPTH(QDEPTH), .RST_PC(RST_PC)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .fetchEn   (fetchEn),
    .fetchAddr (fetchAddr),
    .hit       (hit),
    .foundInst (foundInst),
    .memInstEn (memInstEn),
    .memInst   (memInst),
    .jumpEn    (jumpEn),
    .jumpAddr  (jumpAddr),
    .instValid (instValid),
    .instOut   (instOut),
    .instPc    (instPc),
    .instRe    (instRe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  // Behavioural model
  ent_t        q[$];
  logic [31:0] m_pc    = RST_PC;
  bit          m_wait  = 0;   // a miss is outstanding and its word is wanted
  bit          m_drop  = 0;   // a miss is outstanding but its word is stale
  bit          m_fetch = 0;   // model's fetch request for the current cycle

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: 2 time units after each falling edge, inputs for the cycle are
  // stable and the model reflects the state before the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        chk("rst_fetchEn",   {31'd0, fetchEn},   32'd0);
        chk("rst_fetchAddr", fetchAddr,          RST_PC);
        chk("rst_instValid", {31'd0, instValid}, 32'd0);
        chk("rst_instOut",   instOut,            32'd0);
        chk("rst_instPc",    instPc,             32'd0);
      end else begin
        chk("fetchEn",   {31'd0, fetchEn},   {31'd0, m_fetch});
        chk("fetchAddr", fetchAddr,          m_pc);
        chk("instValid", {31'd0, instValid}, {31'd0, (q.size() != 0)});
        if (q.size() != 0) begin
          chk("instOut", instOut, q[0].inst);
          chk("instPc",  instPc,  q[0].pc);
          if (rdy && instRe && !jumpEn) void'(q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rdy = 1'b0; hit = 1'b0; memInstEn = 1'b0;
    jumpEn = 1'b0; instRe = 1'b0;
    q.delete();
    m_pc = RST_PC; m_wait = 0; m_drop = 0; m_fetch = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle of stimulus plus the model's view of what the coming
  // rising edge does.
  task automatic cycle(input bit i_rdy, input bit i_hit, input bit i_mem,
                       input bit i_jmp, input bit i_re,
                       input logic [31:0] i_jaddr, input logic [31:0] i_minst);
    @(negedge clk);
    rdy       = i_rdy;
    hit       = i_hit;
    foundInst = m_pc ^ 32'hA5A5A5A5;
    memInstEn = i_mem;
    memInst   = i_minst;
    jumpEn    = i_jmp;
    jumpAddr  = i_jaddr;
    instRe    = i_re;
    m_fetch   = i_rdy && !m_wait && !m_drop && (q.size() < QDEPTH) && !i_jmp;
    #3;
    if (!i_rdy) begin
      // frozen
    end else if (i_jmp) begin
      q.delete();
      if (m_wait) begin
        m_wait = 0;
        m_drop = !i_mem;
      end else if (m_drop && i_mem) begin
        m_drop = 0;
      end
      m_pc = i_jaddr;
    end else if (m_fetch) begin
      if (i_hit) begin
        q.push_back('{inst: foundInst, pc: m_pc});
        m_pc = m_pc + 32'd4;
      end else begin
        m_wait = 1;
      end
    end else if (m_wait && i_mem) begin
      q.push_back('{inst: i_minst, pc: m_pc});
      m_pc   = m_pc + 32'd4;
      m_wait = 0;
    end else if (m_drop && i_mem) begin
      m_drop = 0;
    end
  endtask

  initial begin
    do_reset();

    // Sustained hits with the decoder draining every cycle
    repeat (8) cycle(1, 1, 0, 0, 1, 32'h0, 32'h0);

    // Miss at pc 0, return six cycles after the request
    do_reset();
    cycle(1, 0, 0, 0, 1, 32'h0, 32'h0);
    repeat (5) cycle(1, 1, 0, 0, 1, 32'h0, 32'h0);
    cycle(1, 1, 1, 0, 1, 32'h0, 32'h00000013);
    repeat (2) cycle(1, 1, 0, 0, 1, 32'h0, 32'h0);

    // Fill to full, then one pop lets exactly one new hit in
    repeat (7) cycle(1, 1, 0, 0, 0, 32'h0, 32'h0);
    cycle(1, 1, 0, 0, 1, 32'h0, 32'h0);
    repeat (2) cycle(1, 1, 0, 0, 0, 32'h0, 32'h0);

    // Redirect while a miss is outstanding: the return is dropped
    cycle(1, 0, 0, 0, 1, 32'h0, 32'h0);
    cycle(1, 0, 0, 0, 1, 32'h0, 32'h0);
    cycle(1, 0, 0, 1, 0, 32'h100, 32'h0);
    repeat (3) cycle(1, 1, 0, 0, 1, 32'h0, 32'h0);
    cycle(1, 1, 1, 0, 1, 32'h0, 32'hDEADDEAD);
    repeat (3) cycle(1, 1, 0, 0, 1, 32'h0, 32'h0);

    // Redirect and return in the same WAIT cycle
    cycle(1, 0, 0, 0, 1, 32'h0, 32'h0);
    cycle(1, 0, 0, 0, 1, 32'h0, 32'h0);
    cycle(1, 0, 1, 1, 1, 32'h200, 32'hBEEFBEEF);
    repeat (2) cycle(1, 1, 0, 0, 1, 32'h0, 32'h0);

    // Stall with a return presented while frozen, then resume
    cycle(1, 0, 0, 0, 1, 32'h0, 32'h0);
    repeat (3) cycle(0, 0, 1, 0, 1, 32'h0, 32'h55555555);
    cycle(1, 0, 1, 0, 1, 32'h0, 32'h77777777);
    repeat (2) cycle(1, 1, 0, 0, 1, 32'h0, 32'h0);

    // PC wrap past the top of the address space
    cycle(1, 1, 0, 1, 1, 32'hFFFFFFF8, 32'h0);
    repeat (4) cycle(1, 1, 0, 0, 1, 32'h0, 32'h0);

    // Reset while a miss is outstanding
    cycle(1, 0, 0, 0, 1, 32'h0, 32'h0);
    cycle(1, 0, 0, 0, 1, 32'h0, 32'h0);
    do_reset();
    repeat (3) cycle(1, 1, 0, 0, 1, 32'h0, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit          r_rdy, r_hit, r_mem, r_jmp, r_re;
      logic [31:0] r_jaddr;
      if (i == 1500) do_reset();
      r_rdy   = ($urandom_range(99, 0) < 88);
      r_hit   = ($urandom_range(99, 0) < 60);
      r_mem   = (m_wait || m_drop) && ($urandom_range(99, 0) < 30);
      r_jmp   = ($urandom_range(99, 0) < 5);
      r_re    = ($urandom_range(99, 0) < 50);
      r_jaddr = ($urandom_range(1, 0) == 0) ? ($urandom() & 32'hFFFFFFFC) : 32'hFFFFFFF0;
      cycle(r_rdy, r_hit, r_mem, r_jmp, r_re, r_jaddr, $urandom());
    end

    @(negedge clk);
    #4;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
